// File: rtl/dma_mc_ctrl.sv
// dma_mc_ctrl: multi-channel DMA control engine, splits descriptors into 4KB-safe bursts and arbitrates round-robin
// Ports: clk/rstn; per-channel ch_go_i/ch_abort_i/ch_src_i/ch_dst_i/ch_bytes_i in,
// ch_busy_o/ch_done_o/ch_err_o/ch_err_code_o out; registered cmd_* to the datapath; cpl_* completions back.
module dma_mc_ctrl #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_BYTES = 64,
  parameter int MAX_BEATS = 16,
  parameter int MAX_OUT = 4,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        ch_go_i,
  input  logic [NUM_CH-1:0]        ch_abort_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dst_i,
  input  logic [NUM_CH*32-1:0]     ch_bytes_i,
  output logic [NUM_CH-1:0]        ch_busy_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic [NUM_CH-1:0]        ch_err_o,
  output logic [NUM_CH*2-1:0]      ch_err_code_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [ADDR_W-1:0]        cmd_src_o,
  output logic [ADDR_W-1:0]        cmd_dst_o,
  output logic [7:0]               cmd_len_o,
  output logic [CW-1:0]            cmd_ch_o,
  output logic                     cmd_last_o,
  input  logic                     cpl_valid_i,
  input  logic [CW-1:0]            cpl_ch_i,
  input  logic                     cpl_err_i
);
  localparam int LB = $clog2(DATA_BYTES);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(DATA_BYTES - 1);
  localparam logic [31:0] BMASK = 32'(DATA_BYTES - 1);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} st_t;
  logic [ADDR_W-1:0] src_a [NUM_CH];
  logic [ADDR_W-1:0] dst_a [NUM_CH];
  logic [8:0] beats_a [NUM_CH];
  logic [NUM_CH-1:0] elig, last_a, iss;
  logic [CW-1:0] ptr, gnt;
  logic any, load;
  // the command register may reload in the same cycle its content is accepted
  assign load = !cmd_valid_o || cmd_ready_i;
  // first pass searches from the pointer upward, second pass wraps to the lowest eligible
  always_comb begin
    any = 1'b0;
    gnt = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (!any && elig[i] && i >= int'(ptr)) begin
        any = 1'b1;
        gnt = CW'(i);
      end
    for (int i = 0; i < NUM_CH; i++)
      if (!any && elig[i]) begin
        any = 1'b1;
        gnt = CW'(i);
      end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cmd_valid_o <= 1'b0;
      cmd_src_o <= '0;
      cmd_dst_o <= '0;
      cmd_len_o <= '0;
      cmd_ch_o <= '0;
      cmd_last_o <= 1'b0;
      ptr <= '0;
    end else if (load) begin
      cmd_valid_o <= any;
      if (any) begin
        cmd_src_o <= src_a[gnt];
        cmd_dst_o <= dst_a[gnt];
        cmd_len_o <= 8'(beats_a[gnt] - 9'd1);
        cmd_ch_o <= gnt;
        cmd_last_o <= last_a[gnt];
        ptr <= gnt == CW'(NUM_CH - 1) ? '0 : gnt + 1'b1;
      end
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    st_t st, st_nx;
    logic [ADDR_W-1:0] src, dst, s_i, d_i;
    logic [31:0] rem, b_i, bs, bd, m;
    logic [OW-1:0] outc, out_nx;
    logic [1:0] code, code_nx;
    logic go, mis, pend, acc, hold, cpl, cerr, abrt, busy, done, err;
    assign s_i = ch_src_i[c*ADDR_W +: ADDR_W];
    assign d_i = ch_dst_i[c*ADDR_W +: ADDR_W];
    assign b_i = ch_bytes_i[c*32 +: 32];
    always_comb begin
      go = ch_go_i[c] && (st == IDLE || st == DONE || st == ERR);
      mis = |{s_i & AMASK, d_i & AMASK, b_i & BMASK};
      pend = cmd_valid_o && cmd_ch_o == CW'(c);
      acc = pend && cmd_ready_i;
      hold = pend && !cmd_ready_i;
      cpl = cpl_valid_i && cpl_ch_i == CW'(c) && outc != '0;
      cerr = cpl && cpl_err_i && (st == RUN || st == DRAIN);
      abrt = ch_abort_i[c] && st == RUN;
      out_nx = outc + OW'(acc) - OW'(cpl);
      // an already flagged error keeps its code
      code_nx = go ? {1'b0, mis} : code != 2'b00 ? code : abrt ? 2'b11 : cerr ? 2'b10 : 2'b00;
      bs = 32'((13'h1000 - {1'b0, src[11:0]}) >> LB);
      bd = 32'((13'h1000 - {1'b0, dst[11:0]}) >> LB);
      m = rem < 32'(MAX_BEATS) ? rem : 32'(MAX_BEATS);
      m = bs < m ? bs : m;
      m = bd < m ? bd : m;
    end
    // a command sitting in the output register already counts against the outstanding limit
    assign elig[c] = st == RUN && rem != 0 && !abrt && !cerr && 32'(outc) + 32'(pend) < 32'(MAX_OUT);
    assign beats_a[c] = 9'(m);
    assign last_a[c] = m == rem;
    assign src_a[c] = src;
    assign dst_a[c] = dst;
    assign iss[c] = load && any && gnt == CW'(c);
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) st <= IDLE;
      else st <= st_nx;
    // drain ends on the cycle the last completion arrives, unless a command is still held for this channel
    always_comb
      st_nx = go ? (mis ? ERR : b_i == 0 ? DONE : RUN)
            : st == RUN ? ((abrt || cerr || (iss[c] && m == rem)) ? DRAIN : RUN)
            : st == DRAIN ? ((out_nx == '0 && !hold) ? (code_nx != 2'b00 ? ERR : DONE) : DRAIN)
            : st;
    always_comb begin
      busy = st == RUN || st == DRAIN;
      done = st == DONE;
      err = st == ERR;
    end
    always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
        src <= '0;
        dst <= '0;
        rem <= '0;
        outc <= '0;
        code <= '0;
      end else begin
        outc <= out_nx;
        code <= code_nx;
        if (go) begin
          src <= s_i;
          dst <= d_i;
          rem <= b_i >> LB;
        end else if (iss[c]) begin
          src <= src + (ADDR_W'(m) << LB);
          dst <= dst + (ADDR_W'(m) << LB);
          rem <= rem - m;
        end
      end
    assign ch_busy_o[c] = busy;
    assign ch_done_o[c] = done;
    assign ch_err_o[c] = err;
    assign ch_err_code_o[2*c +: 2] = code;
  end
endmodule

// File: tb/tb_dma_mc_ctrl.sv
// tb_dma_mc_ctrl: directed self-checking bench for dma_mc_ctrl
module tb_dma_mc_ctrl;
  localparam int N = 4;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] ch_go_i = '0, ch_abort_i = '0;
  logic [N*AW-1:0] ch_src_i = '0, ch_dst_i = '0;
  logic [N*32-1:0] ch_bytes_i = '0;
  logic [N-1:0] ch_busy_o, ch_done_o, ch_err_o;
  logic [2*N-1:0] ch_err_code_o;
  logic cmd_valid_o, cmd_ready_i = 1'b1;
  logic [AW-1:0] cmd_src_o, cmd_dst_o;
  logic [7:0] cmd_len_o;
  logic [1:0] cmd_ch_o;
  logic cmd_last_o;
  logic cpl_valid_i = 1'b0, cpl_err_i = 1'b0;
  logic [1:0] cpl_ch_i = '0;
  logic [95:0] outs;
  int total = 0, bad = 0;
  int cnt [N];
  always #5 clk = ~clk;
  dma_mc_ctrl dut (
    .clk(clk), .rstn(rstn),
    .ch_go_i(ch_go_i), .ch_abort_i(ch_abort_i),
    .ch_src_i(ch_src_i), .ch_dst_i(ch_dst_i), .ch_bytes_i(ch_bytes_i),
    .ch_busy_o(ch_busy_o), .ch_done_o(ch_done_o), .ch_err_o(ch_err_o), .ch_err_code_o(ch_err_code_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_src_o(cmd_src_o), .cmd_dst_o(cmd_dst_o), .cmd_len_o(cmd_len_o),
    .cmd_ch_o(cmd_ch_o), .cmd_last_o(cmd_last_o),
    .cpl_valid_i(cpl_valid_i), .cpl_ch_i(cpl_ch_i), .cpl_err_i(cpl_err_i)
  );
  assign outs = {ch_busy_o, ch_done_o, ch_err_o, ch_err_code_o, cmd_valid_o,
                 cmd_src_o, cmd_dst_o, cmd_len_o, cmd_ch_o, cmd_last_o};
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_ch(input int c, input logic [31:0] s, input logic [31:0] d, input logic [31:0] b);
    ch_src_i[c*AW +: AW] = s;
    ch_dst_i[c*AW +: AW] = d;
    ch_bytes_i[c*32 +: 32] = b;
    ch_go_i[c] = 1'b1;
  endtask
  task automatic go_pulse;
    @(negedge clk);
    ch_go_i = '0;
  endtask
  task automatic wait_cmd(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [7:0] len, input logic [1:0] c, input logic last);
    int i;
    i = 0;
    cmd_ready_i = 1'b1;
    while (!cmd_valid_o && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk(tag, {cmd_valid_o, cmd_src_o, cmd_dst_o, cmd_len_o, cmd_ch_o, cmd_last_o}, {1'b1, s, d, len, c, last});
    @(negedge clk);
  endtask
  task automatic cpl(input int c, input logic e);
    cpl_valid_i = 1'b1;
    cpl_ch_i = 2'(c);
    cpl_err_i = e;
    @(negedge clk);
    cpl_valid_i = 1'b0;
    cpl_err_i = 1'b0;
  endtask
  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      if (cmd_valid_o && cmd_ready_i) cnt[cmd_ch_o]++;
      @(negedge clk);
    end
  endtask
  task automatic clr_cnt;
    for (int i = 0; i < N; i++) cnt[i] = 0;
  endtask
  task automatic do_reset;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset", 128'(outs), 128'd0);
    rstn = 1'b1;
    @(negedge clk);
    // basic split
    set_ch(0, 32'h1000, 32'h2000, 2048);
    go_pulse;
    chk("t1_busy", ch_busy_o[0], 1);
    chk("t1_early", cmd_valid_o, 0);
    @(negedge clk);
    chk("t1_valid", cmd_valid_o, 1);
    wait_cmd("t1_b0", 32'h1000, 32'h2000, 15, 0, 0);
    wait_cmd("t1_b1", 32'h1400, 32'h2400, 15, 0, 1);
    chk("t1_end", cmd_valid_o, 0);
    cpl(0, 0);
    chk("t1_busy_mid", ch_busy_o[0], 1);
    cpl(0, 0);
    chk("t1_done", {ch_busy_o[0], ch_done_o[0], ch_err_o[0]}, 3'b010);
    // 4KB boundary
    set_ch(0, 32'h0FC0, 32'h8000, 256);
    go_pulse;
    chk("t2_clr", {ch_busy_o[0], ch_done_o[0]}, 2'b10);
    wait_cmd("t2_b0", 32'h0FC0, 32'h8000, 0, 0, 0);
    wait_cmd("t2_b1", 32'h1000, 32'h8040, 2, 0, 1);
    cpl(0, 0);
    cpl(0, 0);
    chk("t2_done", {ch_busy_o[0], ch_done_o[0]}, 2'b01);
    // round-robin
    do_reset;
    set_ch(0, 32'h10000, 32'h20000, 4096);
    set_ch(1, 32'h30000, 32'h40000, 4096);
    go_pulse;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_rr%0d", i), {cmd_valid_o, cmd_ch_o, cmd_src_o, cmd_last_o},
          {1'b1, 2'(i % 2), (i % 2 ? 32'h30000 : 32'h10000) + 32'(i / 2) * 32'h400, i >= 6});
      @(negedge clk);
    end
    chk("t3_end", cmd_valid_o, 0);
    for (int i = 0; i < 4; i++) begin
      cpl(0, 0);
      cpl(1, 0);
    end
    chk("t3_done", ch_done_o[1:0], 2'b11);
    // MAX_OUT stall, then abort mid-RUN
    set_ch(0, 32'h50000, 32'h60000, 8192);
    go_pulse;
    clr_cnt;
    run_count(20);
    chk("t3_stall_cnt", cnt[0], 4);
    chk("t3_stall_valid", cmd_valid_o, 0);
    cpl(0, 0);
    wait_cmd("t3_resume", 32'h51000, 32'h61000, 15, 0, 0);
    ch_abort_i[0] = 1'b1;
    @(negedge clk);
    ch_abort_i = '0;
    chk("t6_abort", {ch_busy_o[0], ch_err_code_o[1:0], cmd_valid_o}, {1'b1, 2'b11, 1'b0});
    for (int i = 0; i < 3; i++) cpl(0, 0);
    chk("t6_abort_drain", ch_busy_o[0], 1);
    cpl(0, 0);
    chk("t6_abort_err", {ch_busy_o[0], ch_done_o[0], ch_err_o[0], ch_err_code_o[1:0]}, 5'b00111);
    // backpressure
    set_ch(2, 32'h3000, 32'h7000, 3072);
    go_pulse;
    wait_cmd("t4_b0", 32'h3000, 32'h7000, 15, 2, 0);
    cmd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_hold%0d", i), {cmd_valid_o, cmd_src_o, cmd_dst_o, cmd_len_o, cmd_ch_o, cmd_last_o},
          {1'b1, 32'h3400, 32'h7400, 8'd15, 2'd2, 1'b0});
      @(negedge clk);
    end
    wait_cmd("t4_b1", 32'h3400, 32'h7400, 15, 2, 0);
    wait_cmd("t4_b2", 32'h3800, 32'h7800, 15, 2, 1);
    chk("t4_end", cmd_valid_o, 0);
    for (int i = 0; i < 3; i++) cpl(2, 0);
    chk("t4_done", {ch_busy_o[2], ch_done_o[2]}, 2'b01);
    // completion error
    do_reset;
    set_ch(0, 32'h1000, 32'h2000, 2048);
    set_ch(1, 32'h9000, 32'hA000, 8192);
    go_pulse;
    clr_cnt;
    run_count(20);
    chk("t5_cnt0", cnt[0], 2);
    chk("t5_cnt1", cnt[1], 4);
    cpl(1, 1);
    clr_cnt;
    run_count(10);
    chk("t5_no_more", cnt[1], 0);
    chk("t5_drain", {ch_busy_o[1], ch_err_code_o[3:2]}, 3'b110);
    for (int i = 0; i < 3; i++) cpl(1, 0);
    chk("t5_err1", {ch_busy_o[1], ch_err_o[1], ch_err_code_o[3:2]}, 4'b0110);
    cpl(0, 0);
    cpl(0, 0);
    chk("t5_done0", {ch_done_o[0], ch_err_o[0]}, 2'b10);
    // misalignment
    set_ch(3, 32'h1004, 32'h2000, 64);
    go_pulse;
    chk("t6_mis", {ch_busy_o[3], ch_err_o[3], ch_err_code_o[7:6]}, 4'b0101);
    clr_cnt;
    run_count(5);
    chk("t6_nocmd", cnt[3], 0);
    // reset mid-transfer
    set_ch(0, 32'h1000, 32'h2000, 4096);
    go_pulse;
    @(negedge clk);
    chk("t6_run", cmd_valid_o, 1);
    rstn = 1'b0;
    #1;
    chk("t6_rst", 128'(outs), 128'd0);
    @(negedge clk);
    rstn = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_mc_ctrl.md
# dma_mc_ctrl

Multi-channel DMA control engine, the parametrised successor to the single-channel DMA function wrapper. It accepts up to NUM_CH independent descriptors (src, dst, bytes) and arbitrates between them round-robin. Each descriptor is split into AXI-legal bursts that never cross a 4 KB boundary. The bursts go out as read/write command pairs to a shared datapath (streamers, FIFO, AXI I/F), and per-channel completions and errors are tracked. The block sits between the CSR block and the datapath; it replaces the single-descriptor FSM.

## Interface
Parameters:
- NUM_CH, 4: number of channels (1..8).
- ADDR_W, 32: address width.
- DATA_BYTES, 64: bus width in bytes (512-bit); power of two.
- MAX_BEATS, 16: maximum beats per burst (1..256).
- MAX_OUT, 4: maximum outstanding bursts per channel.

Ports (vectors are channel-major; channel c occupies slice c):
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, in, 1: clock.
  - rstn, in, 1: asynchronous active-low reset.
- Per-channel control from CSRs:
  - ch_go_i, in, NUM_CH: start pulse per channel.
  - ch_abort_i, in, NUM_CH: abort pulse per channel.
  - ch_src_i, in, NUM_CH*ADDR_W: source address.
  - ch_dst_i, in, NUM_CH*ADDR_W: destination address.
  - ch_bytes_i, in, NUM_CH*32: transfer length in bytes.
- Per-channel status to CSRs:
  - ch_busy_o, out, NUM_CH: channel in RUN or DRAIN.
  - ch_done_o, out, NUM_CH: sticky done flag.
  - ch_err_o, out, NUM_CH: sticky error flag.
  - ch_err_code_o, out, NUM_CH*2: error code. 01 = misaligned, 10 = completion error, 11 = aborted.
- Command to datapath:
  - cmd_valid_o, out, 1: burst command valid.
  - cmd_ready_i, in, 1: datapath accepts the command.
  - cmd_src_o, out, ADDR_W: burst source address.
  - cmd_dst_o, out, ADDR_W: burst destination address.
  - cmd_len_o, out, 8: beats minus 1.
  - cmd_ch_o, out, $clog2(NUM_CH) (minimum 1): owning channel.
  - cmd_last_o, out, 1: final burst of the descriptor.
- Completion from datapath:
  - cpl_valid_i, in, 1: one burst completed.
  - cpl_ch_i, in, $clog2(NUM_CH): channel of the completed burst.
  - cpl_err_i, in, 1: the completed burst had an error response.

## Operation
Per-channel FSM states: IDLE, RUN, DRAIN, DONE, ERROR.

- **IDLE/DONE/ERROR + go:**
  - The channel latches src, dst and bytes, and clears its done, err and code flags.
  - If src, dst or bytes is not a multiple of DATA_BYTES, the channel goes to ERROR with code 01.
  - Else if bytes == 0, the channel goes to DONE.
  - Else the channel goes to RUN with remaining beats = bytes/DATA_BYTES.
- **go while RUN/DRAIN:** ignored.
- **RUN:**
  - The channel is eligible for arbitration when remaining > 0 and outstanding < MAX_OUT.
  - When remaining reaches 0 after an issue, the channel moves to DRAIN.
- **DRAIN:**
  - When outstanding == 0: go to DONE if no error was flagged; otherwise go to ERROR.
- **Abort in RUN:** stop issuing, flag code 11, go to DRAIN. Abort is ignored in any other state.
- **cpl_err_i in RUN/DRAIN:** flag code 10, stop issuing, go to DRAIN. If both abort and completion error occur, the first one flagged keeps its code.

Burst sizing:
- b4k(a) = (4096 - a[11:0]) / DATA_BYTES.
- beats = min(remaining, MAX_BEATS, b4k(src), b4k(dst)).
- After an issue, src and dst each advance by beats*DATA_BYTES and remaining decreases by beats.
- cmd_last_o = 1 when beats == remaining.

Arbiter:
- Round-robin over eligible channels.
- The pointer moves to the channel after the one last granted.

Outstanding counter per channel:
- Increments on cmd handshake for that channel.
- Decrements on cpl_valid_i for that channel.
- Simultaneous increment and decrement leaves it unchanged.
- A completion for a channel with outstanding == 0 is ignored.

## Timing
- Reset: all outputs are 0, all FSMs are IDLE, all counters are 0, the round-robin pointer is 0.
- ch_go_i in cycle t: ch_busy_o is high at t+1, and the earliest cmd_valid_o is at t+2.
- Command output is registered.
  - While cmd_valid_o && !cmd_ready_i, all cmd_* outputs are held stable.
  - A new command can be loaded in the same cycle the previous one is accepted, giving one command per cycle at full throughput.
- The address/remaining update and the outstanding increment take effect at the handshake edge.
- The completion effect on the outstanding counter is visible in the next cycle.
- In DRAIN, the final completion at cycle t sets ch_done_o or ch_err_o at t+1 and clears ch_busy_o at t+1.
- A registered but unaccepted command is not withdrawn by an abort; it completes normally.
- Reset asserted mid-transfer drops everything immediately. No completion tracking survives reset.

## Test plan
1. **Basic split:** DATA_BYTES=64, MAX_BEATS=16. ch0 src=0x1000, dst=0x2000, bytes=2048.
   - Expect two commands: (0x1000, 0x2000, len 15, last 0), then (0x1400, 0x2400, len 15, last 1).
   - After two completions, ch_done_o[0]=1 and ch_busy_o[0]=0.
2. **4 KB boundary:** src=0x0FC0, dst=0x8000, bytes=256.
   - Expect (0x0FC0, 0x8000, len 0), then (0x1000, 0x8040, len 2, last 1).
3. **Round-robin:** ch0 and ch1 both started in the same cycle, 4096 bytes each, cmd_ready_i held at 1, completions returned promptly.
   - Expect cmd_ch_o sequence 0,1,0,1,... with no gaps.
   - Also check the MAX_OUT=4 stall when completions are withheld.
4. **Backpressure:** cmd_ready_i held low for 5 cycles mid-transfer.
   - Expect all cmd_* outputs stable, and no lost or duplicated burst.
5. **Completion error:** cpl_err_i=1 on ch1's first completion.
   - Expect no further ch1 commands, and after drain ch_err_o[1]=1 with code 10.
   - ch0 must complete normally.
6. **Misalignment and reset:**
   - src=0x1004: expect ch_err_o=1, code 01, and no command.
   - Abort mid-RUN: expect code 11 after drain.
   - rstn low mid-transfer: expect all outputs 0 on the next cycle.
